aes_key_schedule_seq: RTL

Iterative AES key-expansion engine that sits directly upstream of the AES round datapath. Loads a 128/192/256-bit cipher key, computes one 32-bit schedule word per clock into an internal word store, then serves 128-bit round keys by round index to the round datapath through a registered read port. Replaces per-round combinational key expansion with a single shared SubWord path.

---
 rtl/aes_pkg.sv | 46 ++++
 rtl/aes_key_schedule_seq_if.sv | 28 ++
 rtl/aes_sbox.sv | 29 ++
 rtl/aes_key_schedule_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length codes, Nk/Nr lookups,
// the controller state type and the GF(2^8) xtime helper used to step rcon.
package aes_pkg;

   localparam logic [1:0] KL_128 = 2'b00;
   localparam logic [1:0] KL_192 = 2'b01;
   localparam logic [1:0] KL_256 = 2'b10;
   localparam logic [1:0] KL_BAD = 2'b11;

   localparam logic [3:0] NK_128 = 4'd4;
   localparam logic [3:0] NK_192 = 4'd6;
   localparam logic [3:0] NK_256 = 4'd8;

   localparam logic [3:0] NR_128 = 4'd10;
   localparam logic [3:0] NR_192 = 4'd12;
   localparam logic [3:0] NR_256 = 4'd14;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_EXPAND = 1'b1
   } ks_state_e;

   // Key length in 32-bit words.
   function automatic logic [3:0] nk_of(input logic [1:0] kl);
      case (kl)
         KL_192:  return NK_192;
         KL_256:  return NK_256;
         default: return NK_128;
      endcase
   endfunction

   // Number of cipher rounds for a key length.
   function automatic logic [3:0] nr_of(input logic [1:0] kl);
      case (kl)
         KL_192:  return NR_192;
         KL_256:  return NR_256;
         default: return NR_128;
      endcase
   endfunction

   // Multiply by x in GF(2^8) modulo the AES polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_key_schedule_seq_if.sv
// Control, key-load and round-key read signals between the key-schedule
// engine (slave) and its controller / round datapath (master).
interface aes_key_schedule_seq_if;

   logic         start;
   logic [1:0]   key_len;
   logic [255:0] key_in;
   logic         busy;
   logic         keys_valid;
   logic         done;
   logic         err;
   logic [3:0]   nr;
   logic         rk_rd;
   logic [3:0]   rk_idx;
   logic [127:0] rk_out;
   logic         rk_valid;

   modport master (
      output start, key_len, key_in, rk_rd, rk_idx,
      input  busy, keys_valid, done, err, nr, rk_out, rk_valid
   );

   modport slave (
      input  start, key_len, key_in, rk_rd, rk_idx,
      output busy, keys_valid, done, err, nr, rk_out, rk_valid
   );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box for one byte, table driven.
module aes_sbox (
   input  logic [7:0] din,
   output logic [7:0] dout
);

   // Entry 0x00 sits in the top byte, so entry b lives at bit offset 8*(255-b) = 8*~b.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign dout = SBOX_TBL[{~din, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES key expansion: one schedule word per clock through a single
// shared SubWord path into a flat register store, then 128-bit round keys
// served by index through a one-cycle registered read port.
// Build option AES_KS_WIDE_KEY_EN: when defined, 192- and 256-bit keys are
// supported; otherwise only 128-bit keys are accepted and the store is 44 words.
module aes_key_schedule_seq
   import aes_pkg::*;
#(
   parameter int NR_MAX = 14
) (
   input logic                   clk,
   input logic                   rst_n,
   aes_key_schedule_seq_if.slave ks
);

`ifdef AES_KS_WIDE_KEY_EN
   localparam int NW = 4 * (NR_MAX + 1);
   localparam int KW = 3;
`else
   localparam int NW = 44;
   localparam int KW = 2;
`endif
   localparam int IW = $clog2(NW + 1);
   localparam int AW = $clog2(NW);

   ks_state_e       state_q, state_d;
   logic [31:0]     w_mem [NW];
   logic [IW-1:0]   i_q;
   logic [IW-1:0]   last_q;
   logic [KW-1:0]   kmod_q;
   logic [7:0]      rcon_q;
   logic [3:0]      nk_q;
   logic [3:0]      nr_q;
   logic            keys_valid_q;
   logic            done_q;
   logic            err_q;
   logic [127:0]    rk_out_p1;
   logic            vld_p1;

   logic            key_ok;
   logic            load_key;
   logic            wr_word;
   logic            finish;
   logic            err_set;
   logic [3:0]      nk_sel;

   logic [31:0]     prev_w;
   logic [31:0]     back_w;
   logic [31:0]     sub_in;
   logic [31:0]     sub_out;
   logic [31:0]     t_w;
   logic [31:0]     new_w;
   logic [AW-1:0]   rd_base;
   logic [127:0]    rk_word;

   assign nk_sel = nk_of(ks.key_len);

`ifdef AES_KS_WIDE_KEY_EN
   assign key_ok = (ks.key_len != KL_BAD);
`else
   assign key_ok = (ks.key_len == KL_128);
`endif

   // Controller state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next state and per-cycle strobes; the cycle after the last word write closes out the run.
   always_comb begin
      state_d  = state_q;
      load_key = 1'b0;
      wr_word  = 1'b0;
      finish   = 1'b0;
      err_set  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ks.start) begin
               if (key_ok) begin
                  load_key = 1'b1;
                  state_d  = ST_EXPAND;
               end else begin
                  err_set = 1'b1;
               end
            end
         end
         ST_EXPAND: begin
            if (i_q > last_q) begin
               finish  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               wr_word = 1'b1;
            end
         end
      endcase
   end

   // Expansion counters, rcon stepping and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_q          <= '0;
         last_q       <= '0;
         kmod_q       <= '0;
         rcon_q       <= 8'h01;
         nk_q         <= NK_128;
         nr_q         <= 4'd0;
         keys_valid_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         done_q <= finish;
         err_q  <= err_set;
         if (load_key) begin
            i_q          <= IW'(nk_sel);
            last_q       <= IW'({nr_of(ks.key_len), 2'b11});
            kmod_q       <= '0;
            rcon_q       <= 8'h01;
            nk_q         <= nk_sel;
            nr_q         <= nr_of(ks.key_len);
            keys_valid_q <= 1'b0;
         end else if (wr_word) begin
            i_q    <= i_q + IW'(1);
            kmod_q <= (kmod_q == KW'(nk_q - 4'd1)) ? '0 : kmod_q + KW'(1);
            if (kmod_q == '0) rcon_q <= xtime(rcon_q);
         end else if (finish) begin
            keys_valid_q <= 1'b1;
         end
      end
   end

   // Same-cycle reads of the 1-back and Nk-back words; RotWord only on kmod==0.
   always_comb begin
      prev_w = w_mem[AW'(i_q - IW'(1))];
      back_w = w_mem[AW'(i_q - IW'(nk_q))];
      sub_in = (kmod_q == '0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
   end

   for (genvar b = 0; b < 4; b++) begin : g_subword
      aes_sbox u_sbox (
         .din  (sub_in[8*b +: 8]),
         .dout (sub_out[8*b +: 8])
      );
   end

   // Select the schedule transform and form the next word.
   always_comb begin
      t_w = prev_w;
      if (kmod_q == '0) begin
         t_w = sub_out ^ {rcon_q, 24'h0};
`ifdef AES_KS_WIDE_KEY_EN
      end else if (nk_q == NK_256 && kmod_q == KW'(4)) begin
         t_w = sub_out;
`endif
      end
      new_w = back_w ^ t_w;
   end

   // Word store: key words on load, one expanded word per EXPAND cycle.
   always_ff @(posedge clk) begin
      if (load_key) begin
         for (int j = 0; j < 8; j++) begin
            if (j < int'(nk_sel)) w_mem[j] <= ks.key_in[255-32*j -: 32];
         end
      end else if (wr_word) begin
         w_mem[AW'(i_q)] <= new_w;
      end
   end

   // Gather the four words of the requested round key.
   always_comb begin
      rd_base = AW'({ks.rk_idx, 2'b00});
      rk_word = {w_mem[rd_base], w_mem[rd_base + AW'(1)],
                 w_mem[rd_base + AW'(2)], w_mem[rd_base + AW'(3)]};
   end

   // Registered round-key read port; out-of-range indices return zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rk_out_p1 <= '0;
         vld_p1    <= 1'b0;
      end else if (ks.rk_rd && keys_valid_q) begin
         vld_p1    <= 1'b1;
         rk_out_p1 <= (ks.rk_idx <= nr_q) ? rk_word : '0;
      end else begin
         vld_p1 <= 1'b0;
      end
   end

   assign ks.busy       = (state_q == ST_EXPAND);
   assign ks.keys_valid = keys_valid_q;
   assign ks.done       = done_q;
   assign ks.err        = err_q;
   assign ks.nr         = nr_q;
   assign ks.rk_out     = rk_out_p1;
   assign ks.rk_valid   = vld_p1;

endmodule
